// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_unit_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_valid;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_valid
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_valid
   );
endinterface : fetch_unit_if

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/valid bus and
// drives the instr / PC+2 / current-PC triplet captured by the IF/ID register.
// A one-entry hold buffer keeps a word that returns while decode is stalled.
module fetch_unit #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic               clk,
   input  logic               rst,
   fetch_unit_if.master       imem,
   input  logic               stall,
   input  logic               redirect,
   input  logic [15:0]        redirect_pc,
   input  logic               halt_in,
   output logic [15:0]        instr_out,
   output logic [15:0]        pc2_out,
   output logic [15:0]        pc_cur_out,
   output logic               valid_out,
   output logic               halted
);

   typedef enum logic [1:0] {
      ST_REQ    = 2'd0,
      ST_HOLD   = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t      r_state;
   logic [15:0] r_pc;
   logic [15:0] r_buf_instr;
   logic [15:0] r_buf_pc;
   logic [15:0] r_instr;
   logic [15:0] r_pc2;
   logic [15:0] r_pc_cur;
   logic        r_valid;
   logic        r_halted;

   logic [15:0] w_pc_plus2;
   logic [15:0] w_buf_pc_plus2;

   // Wrap-around increments; 16'hFFFE + 2 rolls to 16'h0000 silently.
   assign w_pc_plus2     = r_pc + 16'd2;
   assign w_buf_pc_plus2 = r_buf_pc + 16'd2;

   // Request is a pure decode of the state register, forced low while in reset.
   assign imem.imem_req  = (r_state == ST_REQ) & rst;
   assign imem.imem_addr = r_pc;

   assign instr_out  = r_instr;
   assign pc2_out    = r_pc2;
   assign pc_cur_out = r_pc_cur;
   assign valid_out  = r_valid;
   assign halted     = r_halted;

   // Fetch FSM: priority redirect > halt > stall > normal, all outputs registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_REQ;
         r_pc        <= RESET_PC;
         r_buf_instr <= 16'h0000;
         r_buf_pc    <= 16'h0000;
         r_instr     <= NOP_INSTR;
         r_pc2       <= 16'h0000;
         r_pc_cur    <= 16'h0000;
         r_valid     <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         case (r_state)
            ST_REQ, ST_HOLD: begin
               if (redirect) begin
                  // Drop any buffered or in-flight word and restart at the target.
                  r_pc    <= redirect_pc;
                  r_instr <= NOP_INSTR;
                  r_valid <= 1'b0;
                  r_state <= ST_REQ;
               end else if (halt_in) begin
                  r_instr  <= NOP_INSTR;
                  r_valid  <= 1'b0;
                  r_halted <= 1'b1;
                  r_state  <= ST_HALTED;
               end else if (r_state == ST_REQ) begin
                  if (stall) begin
                     if (imem.imem_valid) begin
                        // Park the word so it survives the stall.
                        r_buf_instr <= imem.imem_rdata;
                        r_buf_pc    <= r_pc;
                        r_pc        <= w_pc_plus2;
                        r_state     <= ST_HOLD;
                     end else begin
                        r_state <= ST_REQ;
                     end
                  end else if (imem.imem_valid) begin
                     r_instr  <= imem.imem_rdata;
                     r_pc_cur <= r_pc;
                     r_pc2    <= w_pc_plus2;
                     r_valid  <= 1'b1;
                     r_pc     <= w_pc_plus2;
                  end else begin
                     // Memory still busy: issue a bubble, keep PC fields.
                     r_instr <= NOP_INSTR;
                     r_valid <= 1'b0;
                  end
               end else begin
                  if (stall) begin
                     r_state <= ST_HOLD;
                  end else begin
                     r_instr  <= r_buf_instr;
                     r_pc_cur <= r_buf_pc;
                     r_pc2    <= w_buf_pc_plus2;
                     r_valid  <= 1'b1;
                     r_state  <= ST_REQ;
                  end
               end
            end
            ST_HALTED: begin
               // Only reset leaves this state.
               r_instr  <= NOP_INSTR;
               r_valid  <= 1'b0;
               r_halted <= 1'b1;
            end
            default: begin
               r_state <= ST_REQ;
               r_instr <= NOP_INSTR;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency memory model.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halt_in;
   logic [15:0] instr_out;
   logic [15:0] pc2_out;
   logic [15:0] pc_cur_out;
   logic        valid_out;
   logic        halted;

   int n_vec;
   int n_miss;

   // Memory model state
   int          mem_lat;
   int          m_cnt;
   logic        m_busy;
   logic [15:0] m_addr;

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC  (16'h0000),
      .NOP_INSTR (16'h0800)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem        (bus.master),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt_in     (halt_in),
      .instr_out   (instr_out),
      .pc2_out     (pc2_out),
      .pc_cur_out  (pc_cur_out),
      .valid_out   (valid_out),
      .halted      (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: word at a is 0x1111 * (a/2 + 1), low 16 bits.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      logic [31:0] p;
      p = 32'h0000_1111 * ({16'h0000, a >> 1} + 32'd1);
      return p[15:0];
   endfunction

   // Memory: data becomes valid after mem_lat cycles of a steady request.
   always @(negedge clk) begin
      if (bus.imem_req) begin
         if (m_busy && (bus.imem_addr == m_addr)) begin
            m_cnt = m_cnt + 1;
         end else begin
            m_busy = 1'b1;
            m_addr = bus.imem_addr;
            m_cnt  = 1;
         end
         if (m_cnt >= mem_lat) begin
            bus.imem_valid = 1'b1;
            bus.imem_rdata = mem_word(bus.imem_addr);
         end else begin
            bus.imem_valid = 1'b0;
            bus.imem_rdata = 16'hDEAD;
         end
      end else begin
         m_busy         = 1'b0;
         bus.imem_valid = 1'b0;
         bus.imem_rdata = 16'hDEAD;
      end
   end

   task automatic chk_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec = n_vec + 1;
      if (got !== exp) begin
         n_miss = n_miss + 1;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Sample point: 1 time unit after the falling edge.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset(input int lat);
      rst     = 1'b0;
      mem_lat = lat;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec          = 0;
      n_miss         = 0;
      m_cnt          = 0;
      m_busy         = 1'b0;
      m_addr         = 16'h0000;
      bus.imem_valid = 1'b0;
      bus.imem_rdata = 16'hDEAD;
      stall          = 1'b0;
      redirect       = 1'b0;
      redirect_pc    = 16'h0000;
      halt_in        = 1'b0;
      rst            = 1'b0;
      mem_lat        = 1;

      // ---- reset state
      tick();
      tick();
      chk_vec("rst_instr",  instr_out, 16'h0800);
      chk_vec("rst_pc2",    pc2_out, 16'h0000);
      chk_vec("rst_pccur",  pc_cur_out, 16'h0000);
      chk_vec("rst_valid",  {15'd0, valid_out}, 16'h0000);
      chk_vec("rst_halted", {15'd0, halted}, 16'h0000);
      chk_vec("rst_req",    {15'd0, bus.imem_req}, 16'h0000);
      chk_vec("rst_addr",   bus.imem_addr, 16'h0000);

      // ---- 1-cycle latency, three back-to-back fetches
      rst = 1'b1;
      tick();
      chk_vec("l1_bubble", {15'd0, valid_out}, 16'h0000);
      tick();
      chk_vec("l1_i0",  instr_out, 16'h1111);
      chk_vec("l1_c0",  pc_cur_out, 16'h0000);
      chk_vec("l1_p0",  pc2_out, 16'h0002);
      chk_vec("l1_v0",  {15'd0, valid_out}, 16'h0001);
      tick();
      chk_vec("l1_i1",  instr_out, 16'h2222);
      chk_vec("l1_c1",  pc_cur_out, 16'h0002);
      chk_vec("l1_p1",  pc2_out, 16'h0004);
      chk_vec("l1_v1",  {15'd0, valid_out}, 16'h0001);
      tick();
      chk_vec("l1_i2",  instr_out, 16'h3333);
      chk_vec("l1_c2",  pc_cur_out, 16'h0004);
      chk_vec("l1_p2",  pc2_out, 16'h0006);
      chk_vec("l1_v2",  {15'd0, valid_out}, 16'h0001);

      // ---- 3-cycle latency: two bubbles between instructions
      do_reset(3);
      tick(); tick(); tick();
      tick();
      chk_vec("l3_i0", instr_out, 16'h1111);
      chk_vec("l3_c0", pc_cur_out, 16'h0000);
      tick();
      chk_vec("l3_b0v", {15'd0, valid_out}, 16'h0000);
      chk_vec("l3_b0i", instr_out, 16'h0800);
      chk_vec("l3_b0c", pc_cur_out, 16'h0000);
      tick();
      chk_vec("l3_b1v", {15'd0, valid_out}, 16'h0000);
      tick();
      chk_vec("l3_i1", instr_out, 16'h2222);
      chk_vec("l3_c1", pc_cur_out, 16'h0002);
      tick(); tick();
      chk_vec("l3_b2v", {15'd0, valid_out}, 16'h0000);
      tick();
      chk_vec("l3_i2", instr_out, 16'h3333);
      chk_vec("l3_c2", pc_cur_out, 16'h0004);

      // ---- stall for 4 cycles as 0x2222 returns
      do_reset(1);
      tick();
      tick();
      chk_vec("st_i0", instr_out, 16'h1111);
      stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_vec("st_hold_i", instr_out, 16'h1111);
         chk_vec("st_hold_c", pc_cur_out, 16'h0000);
         chk_vec("st_hold_req", {15'd0, bus.imem_req}, 16'h0000);
      end
      stall = 1'b0;
      tick();
      chk_vec("st_rel_i", instr_out, 16'h2222);
      chk_vec("st_rel_c", pc_cur_out, 16'h0002);
      chk_vec("st_rel_p", pc2_out, 16'h0004);
      chk_vec("st_rel_req", {15'd0, bus.imem_req}, 16'h0001);
      chk_vec("st_rel_addr", bus.imem_addr, 16'h0004);
      tick();
      chk_vec("st_nx_i", instr_out, 16'h3333);
      chk_vec("st_nx_c", pc_cur_out, 16'h0004);

      // ---- redirect while stalled with a full hold buffer
      do_reset(1);
      tick();
      tick();
      stall = 1'b1;
      tick();
      chk_vec("rd_hold_req", {15'd0, bus.imem_req}, 16'h0000);
      redirect    = 1'b1;
      redirect_pc = 16'h0040;
      tick();
      redirect = 1'b0;
      stall    = 1'b0;
      chk_vec("rd_v",    {15'd0, valid_out}, 16'h0000);
      chk_vec("rd_i",    instr_out, 16'h0800);
      chk_vec("rd_addr", bus.imem_addr, 16'h0040);
      tick();
      chk_vec("rd_ni", instr_out, 16'h3331);
      chk_vec("rd_nc", pc_cur_out, 16'h0040);
      chk_vec("rd_np", pc2_out, 16'h0042);

      // ---- halt together with redirect: redirect wins
      halt_in     = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 16'h0100;
      tick();
      halt_in  = 1'b0;
      redirect = 1'b0;
      chk_vec("hr_halted", {15'd0, halted}, 16'h0000);
      chk_vec("hr_addr",   bus.imem_addr, 16'h0100);
      chk_vec("hr_v",      {15'd0, valid_out}, 16'h0000);
      tick();
      chk_vec("hr_i", instr_out, 16'h9991);
      chk_vec("hr_c", pc_cur_out, 16'h0100);

      // ---- halt alone, then ignore redirect/stall while halted
      halt_in = 1'b1;
      tick();
      halt_in     = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 16'h0200;
      stall       = 1'b1;
      chk_vec("h_halted", {15'd0, halted}, 16'h0001);
      chk_vec("h_req",    {15'd0, bus.imem_req}, 16'h0000);
      chk_vec("h_v",      {15'd0, valid_out}, 16'h0000);
      chk_vec("h_i",      instr_out, 16'h0800);
      tick();
      tick();
      chk_vec("h2_halted", {15'd0, halted}, 16'h0001);
      chk_vec("h2_req",    {15'd0, bus.imem_req}, 16'h0000);
      chk_vec("h2_addr",   bus.imem_addr, 16'h0102);
      chk_vec("h2_v",      {15'd0, valid_out}, 16'h0000);

      // ---- asynchronous reset mid-halt
      rst = 1'b0;
      #1;
      chk_vec("hrst_addr",   bus.imem_addr, 16'h0000);
      chk_vec("hrst_halted", {15'd0, halted}, 16'h0000);
      chk_vec("hrst_req",    {15'd0, bus.imem_req}, 16'h0000);
      redirect = 1'b0;
      stall    = 1'b0;

      // ---- redirect to 0xFFFE, PC+2 wraps to 0
      do_reset(1);
      tick();
      redirect    = 1'b1;
      redirect_pc = 16'hFFFE;
      tick();
      redirect = 1'b0;
      chk_vec("wr_addr0", bus.imem_addr, 16'hFFFE);
      tick();
      chk_vec("wr_i",    instr_out, 16'h8000);
      chk_vec("wr_c",    pc_cur_out, 16'hFFFE);
      chk_vec("wr_p",    pc2_out, 16'h0000);
      chk_vec("wr_addr", bus.imem_addr, 16'h0000);
      tick();
      chk_vec("wr_ni", instr_out, 16'h1111);
      chk_vec("wr_nc", pc_cur_out, 16'h0000);
      chk_vec("wr_np", pc2_out, 16'h0002);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage and producer side of the IF/ID pipeline register.
- Keeps the PC, talks to instruction memory over a req/valid handshake, and drives the instr/PC+2/current-PC triplet that the IF/ID register captures.
- Handles downstream stall, branch/jump redirect from later stages, and HALT, with a one-entry hold buffer so a fetched word is not lost under stall.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, instruction word driven on instr_out whenever valid_out=0.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- imem_req  output  1  fetch request; asserted only in state REQ.
- imem_addr  output  16  fetch address; always equals the current PC register.
- imem_rdata  input  16  instruction word; meaningful only when imem_valid=1.
- imem_valid  input  1  memory has returned data for imem_addr this cycle. Latency 1..N cycles. Address may change while waiting.
- stall  input  1  hazard unit holds the IF/ID contents.
- redirect  input  1  taken branch or jump; load redirect_pc.
- redirect_pc  input  16  redirect target.
- halt_in  input  1  decode saw HALT.
- instr_out  output  16  instruction to IF/ID.
- pc2_out  output  16  fetched PC + 2 to IF/ID.
- pc_cur_out  output  16  fetched PC to IF/ID.
- valid_out  output  1  instr_out holds a real instruction.
- halted  output  1  fetch is permanently stopped.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, state=REQ, hold buffer empty.
  - instr_out=NOP_INSTR, pc2_out=0, pc_cur_out=0, valid_out=0, halted=0.
  - imem_req is 0 while rst=0.
- All outputs are registered. Fetched data appears on the outputs the cycle after the imem_valid cycle.
- States:
  - REQ: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0; holds buffered word.
  - HALTED: imem_req=0, halted=1.
- Per-cycle priority: reset > redirect > halt_in > stall > normal.
- REQ, imem_valid=1, stall=0:
  - instr_out=imem_rdata, pc_cur_out=pc, pc2_out=pc+2, valid_out=1.
  - pc <= pc+2.
- REQ, imem_valid=0, stall=0: instr_out=NOP_INSTR, valid_out=0 (bubble). pc2_out and pc_cur_out keep their old values.
- REQ, imem_valid=1, stall=1:
  - Capture {imem_rdata, pc} into the hold buffer; pc <= pc+2; go HOLD.
  - All outputs unchanged.
- REQ, imem_valid=0, stall=1: all outputs and pc unchanged.
- HOLD, stall=1: all outputs unchanged.
- HOLD, stall=0: present the buffered word (instr, pc, pc+2, valid=1), empty the buffer, go REQ. A new request is issued the same cycle.
- redirect=1 in REQ or HOLD, with or without stall:
  - pc <= redirect_pc; discard the hold buffer and any returned data that cycle.
  - instr_out=NOP_INSTR, valid_out=0; go REQ.
- halt_in=1 with redirect=0:
  - Go HALTED; pc frozen; instr_out=NOP_INSTR, valid_out=0; halted=1 from the next cycle.
  - HALTED is left only by reset. redirect, stall and imem_valid are ignored there.
- Arithmetic: pc+2 is modulo 2^16, so 16'hFFFE+2 = 16'h0000 with no flag.
- An odd redirect_pc is loaded as given; the block does not check alignment.

Test Plan:
- Reset release, memory with 1-cycle latency returning 0x1111, 0x2222, 0x3333 at addresses 0, 2, 4 -> valid_out high for 3 consecutive cycles; (instr, pc_cur, pc2) = (0x1111, 0, 2), (0x2222, 2, 4), (0x3333, 4, 6).
- Memory latency 3 cycles -> two valid_out=0 bubbles with instr_out=0x0800 between each instruction; pc_cur_out advances 0, 2, 4.
- stall=1 for 4 cycles on the cycle 0x2222 returns -> outputs frozen at 0x1111, imem_req=0 during HOLD; on release 0x2222 / pc_cur=2 appears, then 0x3333 / pc_cur=4 follows.
- redirect=1, redirect_pc=0x0040 while stall=1 and the hold buffer is full -> next cycle valid_out=0 and imem_addr=0x0040; the buffered word is never issued; the next valid instruction has pc_cur_out=0x0040.
- halt_in and redirect both asserted in the same cycle -> redirect taken, halted stays 0. halt_in alone later -> halted=1, imem_req=0 indefinitely, valid_out=0; asserting rst=0 mid-halt -> immediate return to RESET_PC.
- Redirect to 0xFFFE -> fetched pc2_out=0x0000, then the next fetch address is 0x0000.
